// File: rtl/psg_bus_sequencer_if.sv
// ----------------------------------------------------------------------------
// psg_bus_sequencer_if
//   Groups the request/response handshake and the AY-3-8910 bus pins of the
//   PSG bus sequencer.
//
//   Request side : REQ_VALID, REQ_READY, REQ_WRITE, REQ_ADDR[3:0], REQ_WDATA[7:0]
//   Response side: RSP_VALID (one-cycle pulse), RSP_DATA[7:0]
//   PSG bus side : BDIR, BC1, DA_OUT[7:0], DA_OE, DA_IN[7:0]
//
//   slave  - view taken by the sequencer itself
//   master - view taken by the request source / PSG model
// ----------------------------------------------------------------------------
interface psg_bus_sequencer_if;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic       REQ_WRITE;
    logic [3:0] REQ_ADDR;
    logic [7:0] REQ_WDATA;
    logic       RSP_VALID;
    logic [7:0] RSP_DATA;
    logic       BDIR;
    logic       BC1;
    logic [7:0] DA_OUT;
    logic       DA_OE;
    logic [7:0] DA_IN;

    modport slave (
        input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, DA_IN,
        output REQ_READY, RSP_VALID, RSP_DATA, BDIR, BC1, DA_OUT, DA_OE
    );

    modport master (
        output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, DA_IN,
        input  REQ_READY, RSP_VALID, RSP_DATA, BDIR, BC1, DA_OUT, DA_OE
    );
endinterface

// File: rtl/psg_bus_sequencer.sv
// ----------------------------------------------------------------------------
// psg_bus_sequencer
//   Turns single-cycle register read/write requests into AY-3-8910 bus
//   phases: address latch (BDIR/BC1=11), inactive gap, write (10) or
//   read (01), inactive gap. BC2 is tied high on the board.
//
//   Ports:
//     CPU_CLOCK - sole clock, rising edge
//     RESET_AL  - synchronous active-low reset
//     bus       - psg_bus_sequencer_if.slave (request, response, PSG pins)
//
//   Parameters: ADDR_CYCLES, ACC_CYCLES, GAP_CYCLES (each 1..15 clocks).
//
//   Optional feature macro: PSG_ADDR_CACHE_EN
//     When defined, a request to the same register as the last latched one
//     skips the LATCH and GAP1 phases.
// ----------------------------------------------------------------------------
module psg_bus_sequencer #(
    parameter int unsigned ADDR_CYCLES = 2,
    parameter int unsigned ACC_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic                 CPU_CLOCK,
    input  logic                 RESET_AL,
    psg_bus_sequencer_if.slave   bus
);

    localparam logic [3:0] ADDR_N = 4'(ADDR_CYCLES - 1);
    localparam logic [3:0] ACC_N  = 4'(ACC_CYCLES - 1);
    localparam logic [3:0] GAP_N  = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_GAP1,
        S_ACCESS,
        S_GAP2
    } state_t;

    typedef struct packed {
        logic       bdir;
        logic       bc1;
        logic       oe;
        logic [7:0] da;
    } pins_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       wr_q;
    logic [7:0] wdata_q;
    logic       ready_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    pins_t      pins_q;
    logic       cache_hit;

`ifdef PSG_ADDR_CACHE_EN
    logic [3:0] addr_q;
    logic [3:0] last_addr_q;
    logic       last_vld_q;
`endif

    function automatic pins_t latch_pins(input logic [3:0] a);
        return '{bdir: 1'b1, bc1: 1'b1, oe: 1'b1, da: {4'h0, a}};
    endfunction

    // Reads leave DA_OE low so the bus is never driven while the PSG drives it.
    function automatic pins_t access_pins(input logic wr, input logic [7:0] d);
        if (wr)
            return '{bdir: 1'b1, bc1: 1'b0, oe: 1'b1, da: d};
        else
            return '{bdir: 1'b0, bc1: 1'b1, oe: 1'b0, da: 8'h00};
    endfunction

    always_comb begin
`ifdef PSG_ADDR_CACHE_EN
        cache_hit = last_vld_q && (bus.REQ_ADDR == last_addr_q);
`else
        cache_hit = 1'b0;
`endif
    end

    // Pins are loaded on each transition with the value of the phase being
    // entered, so every bus output comes straight from a flop.
    always_ff @(posedge CPU_CLOCK) begin
        if (!RESET_AL) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            pins_q      <= '0;
`ifdef PSG_ADDR_CACHE_EN
            addr_q      <= '0;
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.REQ_VALID) begin
                        wr_q    <= bus.REQ_WRITE;
                        wdata_q <= bus.REQ_WDATA;
                        ready_q <= 1'b0;
`ifdef PSG_ADDR_CACHE_EN
                        addr_q  <= bus.REQ_ADDR;
`endif
                        if (cache_hit) begin
                            state_q <= S_ACCESS;
                            cnt_q   <= ACC_N;
                            pins_q  <= access_pins(bus.REQ_WRITE, bus.REQ_WDATA);
                        end else begin
                            state_q <= S_LATCH;
                            cnt_q   <= ADDR_N;
                            pins_q  <= latch_pins(bus.REQ_ADDR);
                        end
                    end
                end
                S_LATCH: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_GAP1;
                        cnt_q   <= GAP_N;
                        pins_q  <= '0;
`ifdef PSG_ADDR_CACHE_EN
                        last_addr_q <= addr_q;
                        last_vld_q  <= 1'b1;
`endif
                    end
                end
                S_GAP1: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_ACCESS;
                        cnt_q   <= ACC_N;
                        pins_q  <= access_pins(wr_q, wdata_q);
                    end
                end
                S_ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_GAP2;
                        cnt_q   <= GAP_N;
                        pins_q  <= '0;
                        if (!wr_q) begin
                            rsp_data_q  <= bus.DA_IN;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                S_GAP2: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    pins_q  <= '0;
                end
            endcase
        end
    end

    assign bus.REQ_READY = ready_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_DATA  = rsp_data_q;
    assign bus.BDIR      = pins_q.bdir;
    assign bus.BC1       = pins_q.bc1;
    assign bus.DA_OE     = pins_q.oe;
    assign bus.DA_OUT    = pins_q.da;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// ----------------------------------------------------------------------------
// tb_psg_bus_sequencer
//   Directed bench for psg_bus_sequencer. dut_a uses default timing
//   (2/2/1), dut_b uses ADDR=1, ACC=3, GAP=2. Outputs are sampled on the
//   falling clock edge; inputs change on the falling edge or #1 after the
//   rising edge. Latency is counted in clocks from the cycle in which the
//   request is presented to the first cycle with REQ_READY high again.
// ----------------------------------------------------------------------------
module tb_psg_bus_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    psg_bus_sequencer_if a_if ();
    psg_bus_sequencer_if b_if ();

    psg_bus_sequencer dut_a (
        .CPU_CLOCK (clk),
        .RESET_AL  (rst_n),
        .bus       (a_if.slave)
    );

    psg_bus_sequencer #(
        .ADDR_CYCLES (1),
        .ACC_CYCLES  (3),
        .GAP_CYCLES  (2)
    ) dut_b (
        .CPU_CLOCK (clk),
        .RESET_AL  (rst_n),
        .bus       (b_if.slave)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One falling-edge sample of dut_a against a hand-written expectation.
    task automatic a_cycle(input string tag, input logic [1:0] dc, input logic oe,
                           input logic [7:0] da, input logic rdy, input logic rv);
        @(negedge clk);
        check({tag, " bdir/bc1"}, {a_if.BDIR, a_if.BC1}, dc);
        check({tag, " da_oe"}, a_if.DA_OE, oe);
        if (oe) check({tag, " da_out"}, a_if.DA_OUT, da);
        check({tag, " ready"}, a_if.REQ_READY, rdy);
        check({tag, " rsp_valid"}, a_if.RSP_VALID, rv);
    endtask

    // Called at a falling edge with dut_a idle; returns #1 after the accept edge.
    task automatic a_issue(input logic wr, input logic [3:0] addr, input logic [7:0] wd);
        a_if.REQ_WRITE = wr;
        a_if.REQ_ADDR  = addr;
        a_if.REQ_WDATA = wd;
        a_if.REQ_VALID = 1'b1;
        @(posedge clk);
        #1 a_if.REQ_VALID = 1'b0;
    endtask

    task automatic a_write_full(input string tag, input logic [3:0] addr, input logic [7:0] wd);
        a_issue(1'b1, addr, wd);
        a_cycle({tag, " L1"}, 2'b11, 1'b1, {4'h0, addr}, 1'b0, 1'b0);
        a_cycle({tag, " L2"}, 2'b11, 1'b1, {4'h0, addr}, 1'b0, 1'b0);
        a_cycle({tag, " G1"}, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        a_cycle({tag, " W1"}, 2'b10, 1'b1, wd, 1'b0, 1'b0);
        a_cycle({tag, " W2"}, 2'b10, 1'b1, wd, 1'b0, 1'b0);
        a_cycle({tag, " G2"}, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        a_cycle({tag, " ready@7"}, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    logic [7:0] wd_list [3];
    logic [1:0] exp_b   [8];
    int         acc_cyc [$];
    int         k, n10, n10ok, rv_seen;
    logic       take;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wd_list = '{8'h11, 8'h22, 8'h33};
        exp_b   = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};

        rst_n = 1'b0;
        a_if.REQ_VALID = 1'b0; a_if.REQ_WRITE = 1'b0; a_if.REQ_ADDR = '0;
        a_if.REQ_WDATA = '0;   a_if.DA_IN = '0;
        b_if.REQ_VALID = 1'b0; b_if.REQ_WRITE = 1'b0; b_if.REQ_ADDR = '0;
        b_if.REQ_WDATA = '0;   b_if.DA_IN = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst ready", a_if.REQ_READY, 1'b1);
        check("rst rsp_valid", a_if.RSP_VALID, 1'b0);
        check("rst rsp_data", a_if.RSP_DATA, 8'h00);
        check("rst bdir/bc1", {a_if.BDIR, a_if.BC1}, 2'b00);
        check("rst da_out", a_if.DA_OUT, 8'h00);
        check("rst da_oe", a_if.DA_OE, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write R7 = 8'h38
        a_write_full("wr7", 4'd7, 8'h38);

        // Read R14, PSG returns 8'hA5
        a_if.DA_IN = 8'hA5;
        a_issue(1'b0, 4'd14, 8'h00);
        a_cycle("rd14 L1", 2'b11, 1'b1, 8'h0E, 1'b0, 1'b0);
        a_cycle("rd14 L2", 2'b11, 1'b1, 8'h0E, 1'b0, 1'b0);
        a_cycle("rd14 G1", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        a_cycle("rd14 R1", 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
        a_cycle("rd14 R2", 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
        a_cycle("rd14 G2", 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
        check("rd14 rsp_data", a_if.RSP_DATA, 8'hA5);
        a_if.DA_IN = 8'h5A;
        a_cycle("rd14 idle", 2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("rd14 rsp_data held", a_if.RSP_DATA, 8'hA5);

        // Three back-to-back writes with REQ_VALID held high
        k = 0; n10 = 0; n10ok = 0;
        a_if.REQ_WRITE = 1'b1;
        a_if.REQ_ADDR  = 4'd1;
        a_if.REQ_WDATA = wd_list[0];
        a_if.REQ_VALID = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if ({a_if.BDIR, a_if.BC1} == 2'b10) begin
                n10++;
                if (k > 0 && a_if.DA_OUT == wd_list[k-1]) n10ok++;
            end
            take = a_if.REQ_READY && a_if.REQ_VALID;
            if (take) begin
                acc_cyc.push_back(c);
                k++;
            end
            @(posedge clk);
            #1;
            if (take) begin
                if (k < 3) begin
                    a_if.REQ_ADDR  = 4'(k + 1);
                    a_if.REQ_WDATA = wd_list[k];
                end else begin
                    a_if.REQ_VALID = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("b2b accepts", k, 3);
        if (acc_cyc.size() == 3) begin
            check("b2b gap 1-2", acc_cyc[1] - acc_cyc[0], 7);
            check("b2b gap 2-3", acc_cyc[2] - acc_cyc[1], 7);
        end
        check("b2b write cycles", n10, 6);
        check("b2b write data", n10ok, 6);

        // Reset during the ACCESS phase of a read
        a_if.DA_IN = 8'hC3;
        a_issue(1'b0, 4'd4, 8'h00);
        a_cycle("rdrst L1", 2'b11, 1'b1, 8'h04, 1'b0, 1'b0);
        a_cycle("rdrst L2", 2'b11, 1'b1, 8'h04, 1'b0, 1'b0);
        a_cycle("rdrst G1", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        a_cycle("rdrst R1", 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        a_cycle("rdrst abort", 2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
        check("rdrst rsp_data", a_if.RSP_DATA, 8'h00);
        rst_n = 1'b1;
        rv_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_if.RSP_VALID) rv_seen++;
        end
        check("rdrst no rsp_valid", rv_seen, 0);

        // dut_b: ADDR=1, ACC=3, GAP=2 -> phases 1/2/3/2, ready after 9 clocks
        b_if.REQ_WRITE = 1'b1;
        b_if.REQ_ADDR  = 4'd5;
        b_if.REQ_WDATA = 8'h55;
        b_if.REQ_VALID = 1'b1;
        @(posedge clk);
        #1 b_if.REQ_VALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b phase %0d", i), {b_if.BDIR, b_if.BC1}, exp_b[i]);
            check($sformatf("b busy %0d", i), b_if.REQ_READY, 1'b0);
            if (i == 0) check("b latch da", b_if.DA_OUT, 8'h05);
            if (i == 3) check("b write da", b_if.DA_OUT, 8'h55);
        end
        @(negedge clk);
        check("b ready@9", b_if.REQ_READY, 1'b1);

`ifdef PSG_ADDR_CACHE_EN
        // Repeated register: second write skips LATCH/GAP1
        a_write_full("c1", 4'd8, 8'h81);
        a_issue(1'b1, 4'd8, 8'h82);
        a_cycle("c2 W1", 2'b10, 1'b1, 8'h82, 1'b0, 1'b0);
        a_cycle("c2 W2", 2'b10, 1'b1, 8'h82, 1'b0, 1'b0);
        a_cycle("c2 G2", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        a_cycle("c2 ready@4", 2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
        // Reset drops the cached address
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a_write_full("c3", 4'd8, 8'h83);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/psg_bus_sequencer.md
Name: psg_bus_sequencer

Overview:
- Sequences every access to the sound board AY-3-8910 PSG (IC50) over its multiplexed DA0–DA7 bus.
- Turns single-cycle register read/write requests into the PSG bus phases: latch address (BDIR=1, BC1=1), write (BDIR=1, BC1=0) and read (BDIR=0, BC1=1), separated by inactive phases.
- Sits between the sound-side request source and IC50. Replaces the hard-wired BDIR/BC1 gate decode (IC48/IC49) with programmable phase timing.

Parameters:
- ADDR_CYCLES, 2, clocks in the address-latch phase (1..15)
- ACC_CYCLES, 2, clocks in the write or read phase (1..15)
- GAP_CYCLES, 1, clocks in each inactive phase (1..15)

Ports:
- CPU_CLOCK  input  1  sole clock, rising edge
- RESET_AL  input  1  synchronous active-low reset
- REQ_VALID  input  1  request present
- REQ_READY  output  1  sequencer idle, can accept a request
- REQ_WRITE  input  1  1 = register write, 0 = register read
- REQ_ADDR  input  4  PSG register number R0..R15
- REQ_WDATA  input  8  write data
- RSP_VALID  output  1  one-cycle pulse, read data valid
- RSP_DATA  output  8  read data, held until the next read completes
- BDIR  output  1  to PSG BDIR
- BC1  output  1  to PSG BC1 (BC2 tied high on the board)
- DA_OUT  output  8  data driven onto the PSG DA bus
- DA_OE  output  1  1 = drive DA_OUT onto the bus
- DA_IN  input  8  PSG DA bus read-back

Behaviour:
- Clocking and reset: one clock, CPU_CLOCK. Reset is synchronous and active-low on RESET_AL; it is sampled only on the rising edge of CPU_CLOCK.
- Reset values: state=IDLE, REQ_READY=1, RSP_VALID=0, RSP_DATA=8'h00, BDIR=0, BC1=0, DA_OUT=8'h00, DA_OE=0, phase counter=0, last-address-valid=0.
- Outputs are registered (Moore): BDIR, BC1, DA_OE and DA_OUT are decoded from the registered state and the captured request.
- States: IDLE → LATCH → GAP1 → ACCESS → GAP2 → IDLE.
- IDLE: REQ_READY=1 and bus inactive (BDIR=0, BC1=0, DA_OE=0). When REQ_VALID=1 at an edge, capture REQ_WRITE/REQ_ADDR/REQ_WDATA, clear REQ_READY and go to LATCH. REQ_VALID in any other state is ignored, so no request is captured while busy.
- LATCH: held for ADDR_CYCLES clocks. BDIR=1, BC1=1, DA_OE=1, DA_OUT={4'h0, addr}.
- GAP1: held for GAP_CYCLES clocks. BDIR=0, BC1=0, DA_OE=0.
- ACCESS, write: held for ACC_CYCLES clocks. BDIR=1, BC1=0, DA_OE=1, DA_OUT=wdata.
- ACCESS, read: held for ACC_CYCLES clocks. BDIR=0, BC1=1, DA_OE=0. DA_IN is sampled into RSP_DATA at the edge ending the last ACCESS clock.
- Read response: RSP_VALID=1 for exactly the first GAP2 clock after a read; 0 after writes.
- GAP2: held for GAP_CYCLES clocks. Bus inactive. Then return to IDLE with REQ_READY=1.
- Phase counter: 4-bit, loaded with (N-1) on phase entry, counts down, leaves the phase at 0. No wrap is possible within the legal parameter range.
- Latency: request edge to REQ_READY=1 is ADDR_CYCLES+ACC_CYCLES+2·GAP_CYCLES+1 clocks (defaults: 7).
- DA_OE is never 1 while BC1=1 and BDIR=0, so the sequencer never drives the bus while the PSG does.
- Reset mid-operation: at the reset edge, abort the access and apply reset values. No RSP_VALID for the aborted read; partial PSG writes are not retried.
- Back-to-back requests: REQ_VALID held high through GAP2 is accepted on the first IDLE clock. There is no bubble beyond that single IDLE cycle.

Optional Feature:
- Macro: PSG_ADDR_CACHE_EN.
- Defined: the sequencer keeps the last latched register number and a valid flag. When a captured request has valid=1 and addr==last, IDLE goes straight to ACCESS, skipping LATCH and GAP1; latency drops by ADDR_CYCLES+GAP_CYCLES. The valid flag is set on LATCH completion and cleared by reset.
- Undefined: every request runs the full LATCH/GAP1 sequence, and the cache register and flag are not generated.

Test Plan:
- Reset, then write R7=8'h38 with defaults → BDIR/BC1=11 for 2 clocks with DA_OUT=8'h07; 00 for 1 clock; 10 for 2 clocks with DA_OUT=8'h38, DA_OE=1; 00; REQ_READY back high 7 clocks after accept.
- Read R14 with DA_IN=8'hA5 → BDIR/BC1=01 for 2 clocks with DA_OE=0; RSP_VALID single pulse; RSP_DATA=8'hA5 and held.
- REQ_VALID held high for 3 consecutive writes → each accepted only in IDLE, one-cycle REQ_READY pulse between them, no overlap of bus phases.
- RESET_AL low during the ACCESS phase of a read → next edge BDIR=BC1=0, DA_OE=0, REQ_READY=1, no RSP_VALID.
- Parameters ADDR=1, ACC=3, GAP=2 → phase lengths 1/2/3/2, REQ_READY after 9 clocks.
- With PSG_ADDR_CACHE_EN: write R8 twice → second access has no 11 phase, REQ_READY after 4 clocks; after a reset the next R8 write latches the address again.
